flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Shares the single SPI flash read port between two memory-bus requesters: port 0 is instruction fetch and port 1 is the data load/store unit.
- Uses round-robin arbitration.
- Holds a one-entry read buffer, so repeated reads of the same flash address complete without a new 64-cycle SPI transaction.
- Writes are acknowledged locally and never reach the flash, which is read-only.
- Sits between the two bus masters and the flash controller, in the same clock domain.

Parameters:
- BUFFER_EN, 1, 1 enables the one-entry read buffer; 0 sends every read to flash.
- ADDR_BITS, 24, number of address bits compared for a buffer hit (address_in[ADDR_BITS-1:0]).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- m0_address_in  input  32  port 0 byte address.
- m0_sel_in  input  1  port 0 request, held until m0_ready_out.
- m0_read_in  input  1  1 = read, 0 = write.
- m0_write_mask_in  input  4  ignored.
- m0_write_value_in  input  32  ignored.
- m0_read_value_out  output  32  read data; 0 whenever m0_sel_in = 0.
- m0_ready_out  output  1  one-cycle completion pulse.
- m1_*  same seven ports, same meaning, for port 1.
- flash_address_out  output  32  address to flash controller.
- flash_sel_out  output  1  flash request.
- flash_read_out  output  1  always 1 while flash_sel_out = 1.
- flash_write_mask_out  output  4  constant 0.
- flash_write_value_out  output  32  constant 0.
- flash_read_value_in  input  32  flash read data, valid with flash_ready_in.
- flash_ready_in  input  1  flash completion pulse.

Behaviour:
- Reset (reset_n = 0 at posedge):
  - state = IDLE; flash_sel_out = 0; m0_ready_out = m1_ready_out = 0.
  - Internal data registers = 0; buf_valid = 0.
  - last_grant = 1, so port 0 wins the first tie.
- Requester protocol:
  - A requester holds sel, address and read stable until it samples ready = 1.
  - ready is a registered one-cycle pulse.
  - The cycle after ready, the port is not sampled, so the requester may drop sel or present a new request.
- States: IDLE, FLASH (flash transaction outstanding), RESP (ready pulse cycle).
- IDLE:
  - Candidates are ports with sel = 1 that were not acked in the previous cycle.
  - If there is one candidate, grant it. If there are two, grant the port != last_grant.
  - On grant, set last_grant = granted port and latch granted port, address and read.
  - Write: go to RESP; ready pulses on the next cycle; read_value = 0.
  - Read with BUFFER_EN = 1, buf_valid = 1 and address[ADDR_BITS-1:0] == buf_addr: hit; go to RESP with data = buf_data. Latency from sel to ready is 1 cycle.
  - Otherwise (miss): drive flash_sel_out = 1 and flash_address_out = latched address; go to FLASH.
- FLASH:
  - Hold flash_sel_out and flash_address_out.
  - On flash_ready_in = 1:
    - flash_sel_out <= 0 at that same edge. This is required so the flash controller (negedge logic) does not restart.
    - data <= flash_read_value_in.
    - If BUFFER_EN: buf_addr <= latched address, buf_data <= flash_read_value_in, buf_valid <= 1.
    - Go to RESP.
  - A request arriving on the other port meanwhile waits; it is never dropped.
- RESP:
  - Assert the granted port's ready_out for exactly one cycle.
  - Its read_value_out = data, gated by that port's sel_in.
  - The other port's ready_out stays 0.
  - Next state is IDLE. The just-acked port is excluded from candidates on the following IDLE cycle only.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1 and neither port waits more than one foreign transaction.
- flash_ready_in outside FLASH is ignored.
- Reset mid-transaction:
  - Arbiter returns to IDLE with flash_sel_out = 0.
  - The flash controller must be reset by the same system reset; stray flash_ready_in pulses after reset are ignored per the rule above.
- A port's ready_out never asserts unless that port was granted.

Test Plan:
- Port 0 reads 0x00100000 and flash returns 0xDEADBEEF after 64 cycles → flash_sel_out for one transaction; m0_ready_out pulses once; m0_read_value_out = 0xDEADBEEF; flash_sel_out low at the ready edge.
- Port 1 then reads 0x00100000 with BUFFER_EN = 1 → no flash_sel_out; m1_ready_out one cycle after sel; data 0xDEADBEEF. The same test with BUFFER_EN = 0 → a flash transaction occurs.
- Both ports read different addresses simultaneously from reset → port 0 served first, then port 1; the next simultaneous pair serves port 1 first.
- Port 1 writes 0x12345678 with mask 0xF → m1_ready_out one cycle after sel; flash_sel_out stays 0; m1_read_value_out = 0.
- Continuous requests from both ports for 8 transactions → grant order strictly alternates; each ready is a single-cycle pulse.
- reset_n low during FLASH, then a new port 0 read → flash_sel_out = 0 after reset; buf_valid cleared so the first read misses; stray flash_ready_in while IDLE causes no ready_out.

Source files
------------

// File: rtl/flash_arbiter.sv
// flash_arbiter
//   Shares the single read-only SPI flash port between instruction fetch
//   (port 0) and the data load/store unit (port 1) with round-robin
//   arbitration and a one-entry read buffer. Writes are acknowledged locally
//   and never reach the flash.
//
// Ports
//   clk, reset_n           system clock (posedge), synchronous active-low reset
//   m0_* / m1_*            requester ports: address, sel, read, write mask and
//                          value (ignored), read_value_out, ready_out (1-cycle)
//   flash_*_out            request towards the flash controller (read only)
//   flash_read_value_in    flash data, valid with flash_ready_in
//   flash_ready_in         flash completion pulse
//
// State   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no transaction; pick a candidate port, resolve write / hit / miss
// S_FLASH | flash read outstanding, waiting for flash_ready_in
// S_RESP  | granted port's ready_out is high for this single cycle
module flash_arbiter #(
    parameter int BUFFER_EN = 1,
    parameter int ADDR_BITS = 24
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] m0_address_in,
    input  logic        m0_sel_in,
    input  logic        m0_read_in,
    input  logic [3:0]  m0_write_mask_in,
    input  logic [31:0] m0_write_value_in,
    output logic [31:0] m0_read_value_out,
    output logic        m0_ready_out,

    input  logic [31:0] m1_address_in,
    input  logic        m1_sel_in,
    input  logic        m1_read_in,
    input  logic [3:0]  m1_write_mask_in,
    input  logic [31:0] m1_write_value_in,
    output logic [31:0] m1_read_value_out,
    output logic        m1_ready_out,

    output logic [31:0] flash_address_out,
    output logic        flash_sel_out,
    output logic        flash_read_out,
    output logic [3:0]  flash_write_mask_out,
    output logic [31:0] flash_write_value_out,
    input  logic [31:0] flash_read_value_in,
    input  logic        flash_ready_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLASH = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last_grant;
    logic                 r_gnt;
    logic                 r_prev_resp;
    logic [31:0]          r_data;
    logic [31:0]          r_flash_addr;
    logic                 r_flash_sel;
    logic                 r_buf_valid;
    logic [ADDR_BITS-1:0] r_buf_addr;
    logic [31:0]          r_buf_data;
    logic                 r_m0_ready;
    logic                 r_m1_ready;

    logic                 w_cand0;
    logic                 w_cand1;
    logic                 w_any;
    logic                 w_pick1;
    logic [31:0]          w_req_addr;
    logic                 w_req_read;
    logic                 w_hit;
    logic                 w_unused_inputs;

    // The port acked in the previous cycle is not sampled in the IDLE cycle
    // that follows its ready pulse; it may still be showing the old request.
    assign w_cand0 = m0_sel_in && !(r_prev_resp && !r_gnt);
    assign w_cand1 = m1_sel_in && !(r_prev_resp &&  r_gnt);
    assign w_any   = w_cand0 || w_cand1;

    // On a tie the port that did not win last time is chosen.
    assign w_pick1    = w_cand1 && (!w_cand0 || !r_last_grant);
    assign w_req_addr = w_pick1 ? m1_address_in : m0_address_in;
    assign w_req_read = w_pick1 ? m1_read_in    : m0_read_in;

    // Only the low ADDR_BITS take part in the hit compare, so addresses that
    // differ only above that alias onto the same buffer entry.
    assign w_hit = (BUFFER_EN != 0) && r_buf_valid &&
                   (w_req_addr[ADDR_BITS-1:0] == r_buf_addr);

    assign w_unused_inputs = ^{m0_write_mask_in, m0_write_value_in,
                               m1_write_mask_in, m1_write_value_in};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_prev_resp  <= 1'b0;
            r_data       <= '0;
            r_flash_addr <= '0;
            r_flash_sel  <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_data   <= '0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
        end else begin
            r_prev_resp <= (r_state == S_RESP);
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_pick1;
                        r_last_grant <= w_pick1;
                        if (!w_req_read) begin
                            r_data     <= '0;
                            r_m0_ready <= !w_pick1;
                            r_m1_ready <= w_pick1;
                            r_state    <= S_RESP;
                        end else if (w_hit) begin
                            r_data     <= r_buf_data;
                            r_m0_ready <= !w_pick1;
                            r_m1_ready <= w_pick1;
                            r_state    <= S_RESP;
                        end else begin
                            r_flash_sel  <= 1'b1;
                            r_flash_addr <= w_req_addr;
                            r_state      <= S_FLASH;
                        end
                    end
                end

                S_FLASH: begin
                    if (flash_ready_in) begin
                        // Drop the request on the completing edge so the
                        // controller's negedge logic never sees a second one.
                        r_flash_sel <= 1'b0;
                        r_data      <= flash_read_value_in;
                        if (BUFFER_EN != 0) begin
                            r_buf_valid <= 1'b1;
                            r_buf_addr  <= r_flash_addr[ADDR_BITS-1:0];
                            r_buf_data  <= flash_read_value_in;
                        end
                        r_m0_ready <= !r_gnt;
                        r_m1_ready <= r_gnt;
                        r_state    <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_ready_out      = r_m0_ready;
    assign m1_ready_out      = r_m1_ready;
    assign m0_read_value_out = (r_m0_ready && m0_sel_in) ? r_data : 32'b0;
    assign m1_read_value_out = (r_m1_ready && m1_sel_in) ? r_data : 32'b0;

    assign flash_sel_out         = r_flash_sel;
    assign flash_read_out        = r_flash_sel;
    assign flash_address_out     = r_flash_addr;
    assign flash_write_mask_out  = 4'b0;
    assign flash_write_value_out = 32'b0;

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: directed vector table, multi-cycle
// arbitration / reset sequences, a BUFFER_EN=0 instance, and randomized
// traffic on both ports checked against a transaction-level model.
module tb_flash_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] m0_address_in, m1_address_in, m0_write_value_in, m1_write_value_in;
    logic        m0_sel_in, m1_sel_in, m0_read_in, m1_read_in;
    logic [3:0]  m0_write_mask_in, m1_write_mask_in;
    logic [31:0] m0_read_value_out, m1_read_value_out;
    logic        m0_ready_out, m1_ready_out;
    logic [31:0] flash_address_out, flash_write_value_out, flash_read_value_in;
    logic        flash_sel_out, flash_read_out, flash_ready_in;
    logic [3:0]  flash_write_mask_out;
    logic        fl_ready, fl_stray;
    logic [31:0] fl_data;

    assign flash_ready_in      = fl_ready | fl_stray;
    assign flash_read_value_in = fl_stray ? 32'hBAD0_BAD0 : fl_data;

    flash_arbiter #(.BUFFER_EN(1), .ADDR_BITS(24)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address_in(m0_address_in), .m0_sel_in(m0_sel_in), .m0_read_in(m0_read_in),
        .m0_write_mask_in(m0_write_mask_in), .m0_write_value_in(m0_write_value_in),
        .m0_read_value_out(m0_read_value_out), .m0_ready_out(m0_ready_out),
        .m1_address_in(m1_address_in), .m1_sel_in(m1_sel_in), .m1_read_in(m1_read_in),
        .m1_write_mask_in(m1_write_mask_in), .m1_write_value_in(m1_write_value_in),
        .m1_read_value_out(m1_read_value_out), .m1_ready_out(m1_ready_out),
        .flash_address_out(flash_address_out), .flash_sel_out(flash_sel_out),
        .flash_read_out(flash_read_out), .flash_write_mask_out(flash_write_mask_out),
        .flash_write_value_out(flash_write_value_out),
        .flash_read_value_in(flash_read_value_in), .flash_ready_in(flash_ready_in)
    );

    // Second instance without the read buffer, driven directly by the bench.
    logic        nb_sel, nb_fready, nb_rdy0, nb_rdy1, nb_fsel, nb_fread;
    logic [31:0] nb_addr, nb_fdata, nb_rv0, nb_rv1, nb_faddr, nb_fwval;
    logic [3:0]  nb_fmask;

    flash_arbiter #(.BUFFER_EN(0), .ADDR_BITS(24)) dut_nb (
        .clk(clk), .reset_n(reset_n),
        .m0_address_in(nb_addr), .m0_sel_in(nb_sel), .m0_read_in(1'b1),
        .m0_write_mask_in(4'h0), .m0_write_value_in(32'h0),
        .m0_read_value_out(nb_rv0), .m0_ready_out(nb_rdy0),
        .m1_address_in(32'h0), .m1_sel_in(1'b0), .m1_read_in(1'b1),
        .m1_write_mask_in(4'h0), .m1_write_value_in(32'h0),
        .m1_read_value_out(nb_rv1), .m1_ready_out(nb_rdy1),
        .flash_address_out(nb_faddr), .flash_sel_out(nb_fsel),
        .flash_read_out(nb_fread), .flash_write_mask_out(nb_fmask),
        .flash_write_value_out(nb_fwval),
        .flash_read_value_in(nb_fdata), .flash_ready_in(nb_fready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flash contents: fixed word at the test-plan address, hash elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0010_0000) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- flash controller model ----------------
    int          fl_lat = 64;
    bit          fl_rand = 1'b0;
    int          fl_cnt, cur_lat;
    int          fl_txn = 0;
    logic [31:0] fl_last_addr = '0;

    initial begin
        fl_ready = 1'b0; fl_data = '0; fl_cnt = 0; cur_lat = 1;
        forever begin
            @(negedge clk);
            fl_ready = 1'b0;
            fl_data  = '0;
            if (flash_sel_out && reset_n) begin
                if (fl_cnt == 0) cur_lat = fl_rand ? int'($urandom_range(1, 6)) : fl_lat;
                fl_cnt++;
                if (fl_cnt >= cur_lat) begin
                    fl_ready     = 1'b1;
                    fl_data      = mem(flash_address_out);
                    fl_last_addr = flash_address_out;
                    fl_txn++;
                    fl_cnt = 0;
                end
            end else begin
                fl_cnt = 0;
            end
        end
    end

    // ---------------- protocol monitor (sampled after posedge) ----------------
    logic prev_r0 = 1'b0, prev_r1 = 1'b0, prev_fs = 1'b0, prev_nfs = 1'b0;

    always @(posedge clk) begin
        #1;
        if (m0_ready_out || m1_ready_out) begin
            chk("both ready", 32'(m0_ready_out & m1_ready_out), 32'd0);
            if (m0_ready_out) begin
                chk("m0 pulse width", 32'(prev_r0), 32'd0);
                chk("m0 ready without sel", 32'(m0_sel_in), 32'd1);
            end
            if (m1_ready_out) begin
                chk("m1 pulse width", 32'(prev_r1), 32'd0);
                chk("m1 ready without sel", 32'(m1_sel_in), 32'd1);
            end
        end
        if (!m0_sel_in) chk("m0 rdata gated", m0_read_value_out, 32'd0);
        if (!m1_sel_in) chk("m1 rdata gated", m1_read_value_out, 32'd0);
        if (flash_sel_out && !prev_fs) begin
            chk("flash_read_out", 32'(flash_read_out), 32'd1);
            chk("flash wmask", 32'(flash_write_mask_out), 32'd0);
            chk("flash wvalue", flash_write_value_out, 32'd0);
        end
        if (nb_fsel && !prev_nfs) begin
            chk("nb flash_read_out", 32'(nb_fread), 32'd1);
            chk("nb flash wmask/wvalue", nb_fwval | 32'(nb_fmask), 32'd0);
        end
        chk("nb m1 quiet", nb_rv1 | 32'(nb_rdy1), 32'd0);
        prev_r0  = m0_ready_out;
        prev_r1  = m1_ready_out;
        prev_fs  = flash_sel_out;
        prev_nfs = nb_fsel;
    end

    // ---------------- helpers ----------------
    task automatic drive(input int p, input logic rd, input logic [31:0] a);
        if (p == 0) begin
            m0_sel_in = 1'b1; m0_read_in = rd; m0_address_in = a;
            m0_write_mask_in = 4'hF; m0_write_value_in = $urandom;
        end else begin
            m1_sel_in = 1'b1; m1_read_in = rd; m1_address_in = a;
            m1_write_mask_in = 4'hF; m1_write_value_in = $urandom;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) m0_sel_in = 1'b0;
        else        m1_sel_in = 1'b0;
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? m0_ready_out : m1_ready_out;
    endfunction

    function automatic logic [31:0] rv(input int p);
        return (p == 0) ? m0_read_value_out : m1_read_value_out;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        drop(0); drop(1); nb_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Single transaction from an idle arbiter; k = cycles from sel to ready.
    task automatic do_txn(input int p, input logic rd, input logic [31:0] a, input int lat,
                          output logic [31:0] data, output int k, output int nfl,
                          output logic fsel_at_rdy);
        int  t0;
        bit  got;
        t0 = fl_txn; fl_lat = lat; got = 1'b0; k = 0; data = '0; fsel_at_rdy = 1'b1;
        drive(p, rd, a);
        while (!got && k < 200) begin
            @(negedge clk);
            k++;
            if (rdy(p)) begin
                got = 1'b1; data = rv(p); fsel_at_rdy = flash_sel_out;
            end
        end
        nfl = fl_txn - t0;
        @(negedge clk);
        drop(p);
        @(negedge clk);
    endtask

    // Both ports read at once; report completion order and data.
    task automatic do_pair(input logic [31:0] a0, input logic [31:0] a1,
                           output int first, output int second,
                           output logic [31:0] d0, output logic [31:0] d1);
        bit got0, got1, dr0, dr1;
        got0 = 0; got1 = 0; dr0 = 0; dr1 = 0; first = -1; second = -1; d0 = '0; d1 = '0;
        drive(0, 1'b1, a0);
        drive(1, 1'b1, a1);
        for (int c = 0; c < 400 && !(got0 && got1); c++) begin
            @(negedge clk);
            if (dr0) begin drop(0); dr0 = 0; end
            if (dr1) begin drop(1); dr1 = 0; end
            if (m0_ready_out && !got0) begin
                got0 = 1; d0 = m0_read_value_out; dr0 = 1;
                if (first < 0) first = 0; else second = 0;
            end
            if (m1_ready_out && !got1) begin
                got1 = 1; d1 = m1_read_value_out; dr1 = 1;
                if (first < 0) first = 1; else second = 1;
            end
        end
        @(negedge clk);
        drop(0); drop(1);
        @(negedge clk);
    endtask

    // ---------------- randomized traffic with transaction-level model ----------------
    bit          mb_valid;
    logic [31:0] mb_addr;
    int          mb_txn;
    bit          waiting[2];
    int          foreign[2];

    task automatic rand_port(input int p, input int n_txn);
        logic [31:0] pool[4];
        logic [31:0] a, exp, d;
        logic        rd;
        int          k, dfl;
        bit          got;
        pool = '{32'h0060_0000, 32'h0060_0010, 32'h0760_0000, 32'h0060_0020};
        for (int n = 0; n < n_txn; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rd = ($urandom_range(0, 3) != 0);
            a  = pool[$urandom_range(0, 3)];
            drive(p, rd, a);
            foreign[p] = 0; waiting[p] = 1'b1;
            got = 1'b0; k = 0; d = '0;
            while (!got && k < 200) begin
                @(negedge clk);
                k++;
                if (rdy(p)) begin got = 1'b1; d = rv(p); end
            end
            chk($sformatf("rand p%0d completes", p), 32'(got), 32'd1);
            if (!got) begin drop(p); break; end
            // Serve in completion order: a read hits if its low 24 bits match
            // the last address fetched from flash.
            if (!rd) begin
                exp = '0; dfl = 0;
            end else if (mb_valid && a[23:0] == mb_addr[23:0]) begin
                exp = mem(mb_addr); dfl = 0;
            end else begin
                exp = mem(a); dfl = 1; mb_valid = 1'b1; mb_addr = a;
            end
            chk($sformatf("rand p%0d data @%h", p, a), d, exp);
            chk($sformatf("rand p%0d flash txns", p), 32'(fl_txn - mb_txn), 32'(dfl));
            if (dfl == 1) chk($sformatf("rand p%0d flash addr", p), fl_last_addr, a);
            mb_txn = fl_txn;
            chk($sformatf("rand p%0d foreign waits", p), 32'(foreign[p] > 1), 32'd0);
            waiting[p] = 1'b0;
            if (waiting[1-p]) foreign[1-p]++;
            @(negedge clk);
            drop(p);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] addr;
        int          lat;
        logic [31:0] exp_data;
        int          exp_k;
        int          exp_fl;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [31:0] d, d0, d1;
        int          k, nfl, f1, f2, n, prevp;
        logic        fs;
        bit          saw, got;
        bit          renew[2], done[2];
        logic [31:0] ca[2];

        reset_n = 1'b0; fl_stray = 1'b0;
        m0_sel_in = 0; m1_sel_in = 0; m0_read_in = 1; m1_read_in = 1;
        m0_address_in = '0; m1_address_in = '0;
        m0_write_mask_in = '0; m1_write_mask_in = '0;
        m0_write_value_in = '0; m1_write_value_in = '0;
        nb_sel = 0; nb_addr = '0; nb_fready = 0; nb_fdata = '0;
        repeat (3) @(negedge clk);
        chk("reset flash_sel", 32'(flash_sel_out), 32'd0);
        chk("reset ready", 32'({m0_ready_out, m1_ready_out}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        vt[0] = '{0, 1'b1, 32'h0010_0000, 64, 32'hDEAD_BEEF,      65, 1};
        vt[1] = '{1, 1'b1, 32'h0010_0000,  1, 32'hDEAD_BEEF,       1, 0};
        vt[2] = '{1, 1'b0, 32'h0010_0000,  1, 32'h0,               1, 0};
        vt[3] = '{0, 1'b1, 32'h0020_0000,  5, mem(32'h0020_0000),  6, 1};
        vt[4] = '{0, 1'b1, 32'h0020_0000,  1, mem(32'h0020_0000),  1, 0};
        vt[5] = '{1, 1'b1, 32'h0120_0000,  1, mem(32'h0020_0000),  1, 0};
        vt[6] = '{0, 1'b1, 32'h0020_0004,  3, mem(32'h0020_0004),  4, 1};
        vt[7] = '{1, 1'b1, 32'h0020_0000,  3, mem(32'h0020_0000),  4, 1};
        vt[8] = '{0, 1'b0, 32'h0020_0000,  1, 32'h0,               1, 0};
        vt[9] = '{0, 1'b1, 32'h0020_0000,  1, mem(32'h0020_0000),  1, 0};

        for (int i = 0; i < 10; i++) begin
            do_txn(vt[i].port, vt[i].rd, vt[i].addr, vt[i].lat, d, k, nfl, fs);
            chk($sformatf("vec%0d data", i), d, vt[i].exp_data);
            chk($sformatf("vec%0d latency", i), 32'(k), 32'(vt[i].exp_k));
            chk($sformatf("vec%0d flash txns", i), 32'(nfl), 32'(vt[i].exp_fl));
            chk($sformatf("vec%0d flash_sel at ready", i), 32'(fs), 32'd0);
        end

        // Simultaneous pair from reset: port 0 first.
        do_reset();
        fl_lat = 4;
        do_pair(32'h0030_0000, 32'h0040_0000, f1, f2, d0, d1);
        chk("pair1 first", 32'(f1), 32'd0);
        chk("pair1 second", 32'(f2), 32'd1);
        chk("pair1 d0", d0, mem(32'h0030_0000));
        chk("pair1 d1", d1, mem(32'h0040_0000));
        // After a lone port-0 grant, the next tie goes to port 1.
        do_txn(0, 1'b0, 32'h0030_0000, 1, d, k, nfl, fs);
        chk("lone write latency", 32'(k), 32'd1);
        do_pair(32'h0030_0004, 32'h0040_0004, f1, f2, d0, d1);
        chk("pair2 first", 32'(f1), 32'd1);
        chk("pair2 second", 32'(f2), 32'd0);
        chk("pair2 d0", d0, mem(32'h0030_0004));
        chk("pair2 d1", d1, mem(32'h0040_0004));

        // Continuous requests from both ports: strict alternation from port 0.
        do_reset();
        fl_lat = 2;
        ca[0] = 32'h0080_0000; ca[1] = 32'h0090_0000;
        renew = '{0, 0}; done = '{0, 0};
        drive(0, 1'b1, ca[0]);
        drive(1, 1'b1, ca[1]);
        n = 0; prevp = 1;
        for (int c = 0; c < 600 && !(done[0] && done[1]); c++) begin
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                if (renew[q]) begin
                    renew[q] = 0;
                    if (n >= 8) begin drop(q); done[q] = 1; end
                    else begin ca[q] = ca[q] + 32'd4; drive(q, 1'b1, ca[q]); end
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (rdy(q)) begin
                    chk($sformatf("cont txn%0d port", n), 32'(q), 32'(1 - prevp));
                    chk($sformatf("cont txn%0d data", n), rv(q), mem(ca[q]));
                    prevp = q;
                    n++;
                    renew[q] = 1;
                end
            end
        end
        chk("cont completions", 32'(n), 32'd9);
        drop(0); drop(1);
        @(negedge clk);

        // Reset in the middle of a flash read.
        do_txn(0, 1'b1, 32'h0010_0000, 3, d, k, nfl, fs);
        chk("pre-reset read data", d, 32'hDEAD_BEEF);
        fl_lat = 64;
        drive(0, 1'b1, 32'h0050_0000);
        repeat (10) @(negedge clk);
        chk("mid flash_sel high", 32'(flash_sel_out), 32'd1);
        reset_n = 1'b0;
        drop(0);
        repeat (2) @(negedge clk);
        chk("reset drops flash_sel", 32'(flash_sel_out), 32'd0);
        chk("reset ready low", 32'({m0_ready_out, m1_ready_out}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        fl_stray = 1'b1;
        @(negedge clk);
        fl_stray = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | m0_ready_out | m1_ready_out;
        end
        chk("stray flash_ready ignored", 32'(saw), 32'd0);
        chk("idle flash_sel", 32'(flash_sel_out), 32'd0);
        do_txn(0, 1'b1, 32'h0010_0000, 3, d, k, nfl, fs);
        chk("post-reset miss flash txns", 32'(nfl), 32'd1);
        chk("post-reset miss latency", 32'(k), 32'd4);
        chk("post-reset data", d, 32'hDEAD_BEEF);

        // BUFFER_EN = 0: a repeated read goes to flash again.
        for (int r = 0; r < 2; r++) begin
            nb_addr = 32'h0010_0000; nb_sel = 1'b1; saw = 1'b0; got = 1'b0; d = '0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                nb_fready = 1'b0;
                if (nb_rdy0) begin
                    got = 1'b1; d = nb_rv0;
                end else if (nb_fsel && !saw) begin
                    chk($sformatf("nb read%0d flash addr", r), nb_faddr, 32'h0010_0000);
                    nb_fready = 1'b1; nb_fdata = 32'hCAFE_F00D; saw = 1'b1;
                end
            end
            nb_fready = 1'b0;
            chk($sformatf("nb read%0d used flash", r), 32'(saw), 32'd1);
            chk($sformatf("nb read%0d data", r), d, 32'hCAFE_F00D);
            @(negedge clk);
            nb_sel = 1'b0;
            @(negedge clk);
        end

        // Randomized traffic on both ports.
        do_reset();
        fl_rand = 1'b1;
        mb_valid = 1'b0; mb_addr = '0; mb_txn = fl_txn;
        waiting = '{0, 0}; foreign = '{0, 0};
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        fl_rand = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
